// File: rtl/core_instr_port_if.sv
// core_instr_port_if: core-side command/response handshake bundle.
//
// Handshake rule for both channels: a transfer happens on a rising s_clk edge
// where valid && ready are both high. The source holds its fields stable while
// valid is high and not yet accepted. Ready may be high without valid.
interface core_instr_port_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_addr;
  logic [31:0] rsp_data;

  // The instruction port is the command source and the response sink.
  modport master (
    output cmd_valid, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

  // The core is the command sink and the response source.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/core_instr_port.sv
// core_instr_port: terminal <-> core instruction bridge.
// A command FIFO captures terminal writes on the rising edge of wr. A response
// FIFO collects core responses and is popped on the rising edge of rd.
// Optional feature macro: CORE_INSTR_PORT_ECHO_EN (each accepted command also
// queues an echo response with addr bit 15 set).
module core_instr_port #(
  parameter int DEPTH = 4
) (
  input  logic                 s_clk,
  input  logic                 s_reset,
  input  logic                 wr,
  input  logic [63:0]          wr_instruction,
  output logic                 wr_busy,
  input  logic                 rd,
  output logic                 rd_valid,
  output logic [63:0]          rd_instruction,
  output logic                 cmd_overflow,
  core_instr_port_if.master    core
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Command FIFO state
  logic [47:0]   cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wptr, cmd_rptr;
  logic [CW-1:0] cmd_count, cmd_count_nxt;
  logic          cmd_full, cmd_push, cmd_pop;

  // Response FIFO state
  logic [47:0]   rsp_mem [DEPTH];
  logic [AW-1:0] rsp_wptr, rsp_rptr;
  logic [CW-1:0] rsp_count;
  logic          rsp_full, rsp_push, rsp_pop, rsp_ready_int;
  logic [47:0]   rsp_push_data;

  // Edge detectors; reset to 1 so a level held across reset release is ignored
  logic wr_q, rd_q;
  logic wr_edge, rd_edge;

  assign wr_edge = wr & ~wr_q;
  assign rd_edge = rd & ~rd_q;

  // Register the terminal strobes for edge detection
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      wr_q <= 1'b1;
      rd_q <= 1'b1;
    end else begin
      wr_q <= wr;
      rd_q <= rd;
    end
  end

  // ---------------- command FIFO ----------------
  assign cmd_full       = (cmd_count == CW'(DEPTH));
  assign core.cmd_valid = (cmd_count != '0);
  assign cmd_pop        = core.cmd_valid & core.cmd_ready;
  // A capture while full is only accepted when the head leaves this cycle.
  assign cmd_push       = wr_edge & (~cmd_full | cmd_pop);

  assign core.cmd_addr = core.cmd_valid ? cmd_mem[cmd_rptr][15:0]  : 16'd0;
  assign core.cmd_data = core.cmd_valid ? cmd_mem[cmd_rptr][47:16] : 32'd0;

  // Next command count from push/pop combination
  always_comb begin
    cmd_count_nxt = cmd_count;
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_count_nxt = cmd_count + CW'(1);
      2'b01:   cmd_count_nxt = cmd_count - CW'(1);
      default: cmd_count_nxt = cmd_count;
    endcase
  end

  // Command pointers, count, busy flag and sticky overflow
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      cmd_wptr     <= '0;
      cmd_rptr     <= '0;
      cmd_count    <= '0;
      wr_busy      <= 1'b0;
      cmd_overflow <= 1'b0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + AW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + AW'(1);
      cmd_count <= cmd_count_nxt;
      wr_busy   <= (cmd_count_nxt == CW'(DEPTH));
      if (wr_edge && !cmd_push) cmd_overflow <= 1'b1;
    end
  end

  // Command storage: {data, addr}; bits [31:16] of the instruction are unused
  always_ff @(posedge s_clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= {wr_instruction[63:32], wr_instruction[15:0]};
  end

  // ---------------- response FIFO ----------------
  assign rsp_full = (rsp_count == CW'(DEPTH));
  assign rd_valid = (rsp_count != '0);
  assign rsp_pop  = rd_edge & rd_valid;

`ifdef CORE_INSTR_PORT_ECHO_EN
  logic echo_push;
  // Echo wins over the core; dropped if the FIFO stays full this cycle.
  assign echo_push     = cmd_push & (~rsp_full | rsp_pop);
  assign rsp_ready_int = ~rsp_full & ~echo_push;
  assign rsp_push      = echo_push | (core.rsp_valid & rsp_ready_int);
  assign rsp_push_data = echo_push
                         ? {wr_instruction[63:32], wr_instruction[15:0] | 16'h8000}
                         : {core.rsp_data, core.rsp_addr};
`else
  assign rsp_ready_int = ~rsp_full;
  assign rsp_push      = core.rsp_valid & rsp_ready_int;
  assign rsp_push_data = {core.rsp_data, core.rsp_addr};
`endif

  assign core.rsp_ready = rsp_ready_int;

  assign rd_instruction = rd_valid
                          ? {rsp_mem[rsp_rptr][47:16], 16'd0, rsp_mem[rsp_rptr][15:0]}
                          : 64'd0;

  // Response pointers and count
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      rsp_wptr  <= '0;
      rsp_rptr  <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + AW'(1);
      if (rsp_pop)  rsp_rptr <= rsp_rptr + AW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + CW'(1);
        2'b01:   rsp_count <= rsp_count - CW'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Response storage: {data, addr}
  always_ff @(posedge s_clk) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= rsp_push_data;
  end

endmodule
